// File: rtl/rom_dumper_if.sv
// Control, ROM read-port and serial-out signals of the ROM dumper.
interface rom_dumper_if #(
   parameter int ADDR_WIDTH = 11
);
   logic                  start;
   logic [ADDR_WIDTH-1:0] start_addr;
   logic [ADDR_WIDTH:0]   word_count;
   logic                  busy;
   logic                  done;
   logic [ADDR_WIDTH-1:0] program_rom_read_addr;
   logic [31:0]           program_rom_read_data;
   logic                  tx;

   modport master (
      output start, start_addr, word_count, program_rom_read_data,
      input  busy, done, program_rom_read_addr, tx
   );

   modport slave (
      input  start, start_addr, word_count, program_rom_read_data,
      output busy, done, program_rom_read_addr, tx
   );
endinterface

// File: rtl/rom_dumper.sv
// Reads a range of program ROM words and streams them over 8N1 UART,
// four bytes per word LSB first, followed by an XOR checksum byte.
module rom_dumper #(
   parameter int CLKS_PER_BIT = 868,
   parameter int ADDR_WIDTH   = 11
) (
   input  logic       clk,
   input  logic       reset,
   rom_dumper_if.slave bus
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_LATCH, S_SEND, S_CHECK, S_FINISH
   } state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      clk_cnt_q, clk_cnt_d;
   logic [3:0]            bit_idx_q, bit_idx_d;   // 0 start, 1..8 data, 9 stop
   logic [1:0]            byte_idx_q, byte_idx_d;
   logic [7:0]            shift_q, shift_d;
   logic [31:0]           word_q, word_d;
   logic [ADDR_WIDTH:0]   words_left_q, words_left_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [7:0]            checksum_q, checksum_d;
   logic                  tx_q, tx_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;

   logic                  accept;
   logic                  bit_end;
   logic                  last_byte;
   logic [7:0]            next_byte;

   assign accept    = bus.start && !busy_q && (state_q == S_IDLE || state_q == S_FINISH);
   assign bit_end   = (clk_cnt_q == CNT_LAST);
   assign last_byte = (byte_idx_q == 2'd3);

   assign bus.busy                  = busy_q;
   assign bus.done                  = done_q;
   assign bus.program_rom_read_addr = addr_q;
   assign bus.tx                    = tx_q;

   // Byte of the held word that follows the one currently on the line.
   always_comb begin
      next_byte = word_q[31:24];
      unique case (byte_idx_q)
         2'd0:    next_byte = word_q[15:8];
         2'd1:    next_byte = word_q[23:16];
         default: next_byte = word_q[31:24];
      endcase
   end

   // State and datapath registers; reset aborts any frame with tx high.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         clk_cnt_q    <= '0;
         bit_idx_q    <= 4'd9;
         byte_idx_q   <= '0;
         shift_q      <= '0;
         word_q       <= '0;
         words_left_q <= '0;
         addr_q       <= '0;
         checksum_q   <= '0;
         tx_q         <= 1'b1;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         clk_cnt_q    <= clk_cnt_d;
         bit_idx_q    <= bit_idx_d;
         byte_idx_q   <= byte_idx_d;
         shift_q      <= shift_d;
         word_q       <= word_d;
         words_left_q <= words_left_d;
         addr_q       <= addr_d;
         checksum_q   <= checksum_d;
         tx_q         <= tx_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   // Next state. FETCH/LATCH sit inside the previous stop bit (or the
   // two idle cycles after start), so the bit counter keeps running there
   // and LATCH always falls on the last cycle of a bit period.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE, S_FINISH: begin
            if (state_q == S_FINISH) state_d = S_IDLE;
            if (accept) state_d = (bus.word_count == '0) ? S_FINISH : S_FETCH;
         end
         S_FETCH: if (clk_cnt_q == CNT_PRE) state_d = S_LATCH;
         S_LATCH: state_d = S_SEND;
         S_SEND: begin
            if (last_byte && bit_end) begin
               if (bit_idx_q == 4'd8 && words_left_q != '0) state_d = S_FETCH;
               else if (bit_idx_q == 4'd9)                  state_d = S_CHECK;
            end
         end
         S_CHECK: if (bit_end && bit_idx_q == 4'd9) state_d = S_FINISH;
         default: state_d = S_IDLE;
      endcase
   end

   // Serializer, ROM addressing, checksum and status outputs.
   always_comb begin
      clk_cnt_d    = clk_cnt_q;
      bit_idx_d    = bit_idx_q;
      byte_idx_d   = byte_idx_q;
      shift_d      = shift_q;
      word_d       = word_q;
      words_left_d = words_left_q;
      addr_d       = addr_q;
      checksum_d   = checksum_q;
      tx_d         = tx_q;

      if (accept) begin
         addr_d       = bus.start_addr;
         words_left_d = bus.word_count;
         checksum_d   = '0;
         clk_cnt_d    = CNT_PRE;
      end

      if (state_q inside {S_FETCH, S_LATCH, S_SEND, S_CHECK})
         clk_cnt_d = bit_end ? '0 : clk_cnt_q + 1'b1;

      if (state_q == S_LATCH) begin
         word_d       = bus.program_rom_read_data;
         shift_d      = bus.program_rom_read_data[7:0];
         checksum_d   = checksum_q ^ bus.program_rom_read_data[7:0];
         addr_d       = addr_q + 1'b1;
         words_left_d = words_left_q - 1'b1;
         byte_idx_d   = '0;
         bit_idx_d    = '0;
         tx_d         = 1'b0;
      end

      if ((state_q == S_SEND || state_q == S_CHECK) && bit_end) begin
         if (bit_idx_q != 4'd9) begin
            bit_idx_d = bit_idx_q + 1'b1;
            tx_d      = (bit_idx_q == 4'd8) ? 1'b1 : shift_q[bit_idx_q[2:0]];
         end else if (state_q == S_SEND) begin
            bit_idx_d = '0;
            tx_d      = 1'b0;
            if (!last_byte) begin
               byte_idx_d = byte_idx_q + 1'b1;
               shift_d    = next_byte;
               checksum_d = checksum_q ^ next_byte;
            end else begin
               shift_d = checksum_q;
            end
         end
      end

      busy_d = accept || (state_d inside {S_FETCH, S_LATCH, S_SEND, S_CHECK});
      done_d = (state_d == S_FINISH);
   end

endmodule

// File: tb/tb_rom_dumper.sv
// Directed bench for rom_dumper: decodes the UART stream at exact cycle
// positions and compares against hand-computed bytes and timings.
module tb_rom_dumper;

   localparam int CPB      = 4;
   localparam int FRAME    = 10 * CPB;
   localparam int WORD_CYC = 4 * FRAME;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   rom_dumper_if #(.ADDR_WIDTH(11)) bus_a ();
   rom_dumper_if #(.ADDR_WIDTH(8))  bus_b ();

   rom_dumper #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(11)) dut_a (
      .clk(clk), .reset(reset), .bus(bus_a)
   );
   rom_dumper #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(8)) dut_b (
      .clk(clk), .reset(reset), .bus(bus_b)
   );

   logic [31:0] rom_a [0:2047];
   logic [31:0] rom_b [0:255];
   always @(posedge clk) bus_a.program_rom_read_data <= rom_a[bus_a.program_rom_read_addr];
   always @(posedge clk) bus_b.program_rom_read_data <= rom_b[bus_b.program_rom_read_addr];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int   sel = 0;
   logic tx_m, busy_m, done_m;
   logic [31:0] addr_m;
   always_comb begin
      tx_m   = (sel != 0) ? bus_b.tx   : bus_a.tx;
      busy_m = (sel != 0) ? bus_b.busy : bus_a.busy;
      done_m = (sel != 0) ? bus_b.done : bus_a.done;
      addr_m = (sel != 0) ? 32'(bus_b.program_rom_read_addr) : 32'(bus_a.program_rom_read_addr);
   end

   int n_checks = 0;
   int n_errs   = 0;

   logic [7:0] exp_bytes [$];
   logic [7:0] rx_bytes  [$];
   int         exp_addrs [$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic drive_start(input int s, input int addr, input int wc);
      if (s == 0) begin
         bus_a.start      = 1'b1;
         bus_a.start_addr = 11'(addr);
         bus_a.word_count = 12'(wc);
      end else begin
         bus_b.start      = 1'b1;
         bus_b.start_addr = 8'(addr);
         bus_b.word_count = 9'(wc);
      end
   endtask

   task automatic release_start();
      bus_a.start = 1'b0;
      bus_b.start = 1'b0;
   endtask

   // Start a dump and follow it cycle by cycle until one cycle after done.
   // inject_k > 0 pulses a second (ignored) start on instance A at that cycle.
   task automatic run_dump(input int s, input int addr, input int wc,
                           input int inject_k, input string tag);
      int n_frames, last_k, t0, busy_cnt, ctl_err, frm_err, first_low, ai, bad;
      int pos, b, c;
      logic [7:0] cur;
      logic       bitval;
      n_frames  = 4 * wc + 1;
      last_k    = 3 + n_frames * FRAME;
      busy_cnt  = 0;
      ctl_err   = 0;
      frm_err   = 0;
      first_low = -1;
      ai        = 0;
      cur       = '0;
      bitval    = 1'b1;
      rx_bytes.delete();
      sel = s;
      @(negedge clk);
      drive_start(s, addr, wc);
      t0 = cyc;
      for (int k = 1; k <= last_k; k++) begin
         @(negedge clk);
         if (k == 1) release_start();
         if (inject_k > 0 && k == inject_k) drive_start(0, 0, 2);
         if (inject_k > 0 && k == inject_k + 1) release_start();
         if (tx_m === 1'b0 && first_low < 0) first_low = k;
         if ((k - 1) % WORD_CYC == 0 && ai < exp_addrs.size()) begin
            check({tag, "_addr"}, addr_m, 32'(exp_addrs[ai]));
            ai++;
         end
         if (k < last_k) begin
            if (busy_m === 1'b1) busy_cnt++;
            if (done_m !== 1'b0) ctl_err++;
         end
         if (k < 3) begin
            if (tx_m !== 1'b1) frm_err++;
         end else if (k < last_k) begin
            pos = k - 3;
            b   = (pos % FRAME) / CPB;
            c   = pos % CPB;
            if (c == 0) begin
               bitval = tx_m;
               if (b == 0 && tx_m !== 1'b0) frm_err++;
               if (b == 9 && tx_m !== 1'b1) frm_err++;
               if (b >= 1 && b <= 8) cur[b-1] = tx_m;
            end else if (tx_m !== bitval) begin
               frm_err++;
            end
            if (b == 9 && c == CPB - 1) rx_bytes.push_back(cur);
         end else begin
            check({tag, "_done"}, 32'(done_m), 32'd1);
            check({tag, "_busy_at_done"}, 32'(busy_m), 32'd0);
            check({tag, "_done_cycle"}, 32'(cyc - t0), 32'(last_k));
         end
      end
      check({tag, "_first_low"}, 32'(first_low), 32'd3);
      check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(2 + n_frames * FRAME));
      check({tag, "_ctl_errs"}, 32'(ctl_err), 32'd0);
      check({tag, "_frame_errs"}, 32'(frm_err), 32'd0);
      check({tag, "_nbytes"}, 32'(rx_bytes.size()), 32'(exp_bytes.size()));
      if (rx_bytes.size() == exp_bytes.size()) begin
         if (exp_bytes.size() <= 16) begin
            foreach (exp_bytes[i]) check($sformatf("%s_byte%0d", tag, i), 32'(rx_bytes[i]), 32'(exp_bytes[i]));
         end else begin
            bad = 0;
            foreach (exp_bytes[i]) if (rx_bytes[i] !== exp_bytes[i]) bad++;
            check({tag, "_bad_bytes"}, 32'(bad), 32'd0);
            check({tag, "_checksum"}, 32'(rx_bytes[rx_bytes.size()-1]), 32'h00);
         end
      end
      @(negedge clk);
      check({tag, "_done_pulse_end"}, 32'(done_m), 32'd0);
   endtask

   initial begin
      int t0, err;
      reset = 1'b1;
      release_start();
      bus_a.start_addr = '0;
      bus_a.word_count = '0;
      bus_b.start_addr = '0;
      bus_b.word_count = '0;
      for (int i = 0; i < 2048; i++) rom_a[i] = 32'hDEAD_0000 | 32'(i);
      for (int i = 0; i < 256; i++)  rom_b[i] = 32'(i);
      rom_a[5]    = 32'h0403_0201;
      rom_a[2047] = 32'hAABB_CCDD;
      rom_a[0]    = 32'h1122_3344;

      repeat (3) @(negedge clk);
      check("rst_tx",   32'(bus_a.tx),   32'd1);
      check("rst_busy", 32'(bus_a.busy), 32'd0);
      check("rst_done", 32'(bus_a.done), 32'd0);
      check("rst_addr", 32'(bus_a.program_rom_read_addr), 32'd0);
      check("rst_tx_b", 32'(bus_b.tx),   32'd1);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // Single word
      exp_bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
      exp_addrs = '{5};
      run_dump(0, 5, 1, 0, "one");

      // Address wrap 2047 -> 0; checksum DD^CC^BB^AA^44^33^22^11 = 44
      exp_bytes = '{8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h44, 8'h33, 8'h22, 8'h11, 8'h44};
      exp_addrs = '{2047, 0};
      run_dump(0, 2047, 2, 0, "wrap");

      // Zero words: one busy cycle, done at T+1, nothing sent
      sel = 0;
      @(negedge clk);
      drive_start(0, 9, 0);
      @(negedge clk);
      release_start();
      check("zero_busy_t1", 32'(bus_a.busy), 32'd1);
      check("zero_done_t1", 32'(bus_a.done), 32'd1);
      @(negedge clk);
      check("zero_busy_t2", 32'(bus_a.busy), 32'd0);
      check("zero_done_t2", 32'(bus_a.done), 32'd0);
      err = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (bus_a.tx !== 1'b1 || bus_a.done !== 1'b0 || bus_a.busy !== 1'b0) err++;
      end
      check("zero_quiet", 32'(err), 32'd0);

      // Second start mid-dump is ignored
      exp_bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
      exp_addrs = '{5};
      run_dump(0, 5, 1, 50, "ignore");

      // Reset during data bits of byte 2 (frame starts T+83)
      sel = 0;
      @(negedge clk);
      drive_start(0, 5, 1);
      t0 = cyc;
      for (int k = 1; k <= 95; k++) begin
         @(negedge clk);
         if (k == 1) release_start();
      end
      check("midrst_elapsed", 32'(cyc - t0), 32'd95);
      reset = 1'b1;
      #1;
      check("midrst_tx",   32'(bus_a.tx),   32'd1);
      check("midrst_busy", 32'(bus_a.busy), 32'd0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      err = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (bus_a.done !== 1'b0 || bus_a.tx !== 1'b1) err++;
      end
      check("midrst_no_done", 32'(err), 32'd0);
      exp_bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
      exp_addrs = '{5};
      run_dump(0, 5, 1, 0, "after_rst");

      // Full address range on the 8-bit instance: ROM[i]=i, checksum 00
      exp_bytes.delete();
      exp_addrs.delete();
      for (int i = 0; i < 256; i++) begin
         exp_bytes.push_back(8'(i));
         exp_bytes.push_back(8'h00);
         exp_bytes.push_back(8'h00);
         exp_bytes.push_back(8'h00);
      end
      exp_bytes.push_back(8'h00);
      run_dump(1, 0, 256, 0, "full");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end

endmodule
